// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the SRAM-like request arbiter.
//   owner_e     : 1-bit owner tag stored per outstanding transaction
//   arb_state_e : arbiter FSM state encoding
//   sram_req_t  : one requester's request bundle (everything but req itself)
//   SIZE_*      : SRAM-like transfer size codes
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD_I = 2'd1,
        S_HOLD_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Field order matches the mem_* output concatenation in the top level.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    // HOLD state that locks the grant to a given owner.
    function automatic arb_state_e hold_state(input owner_e own);
        return (own == OWN_DATA) ? S_HOLD_D : S_HOLD_I;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// ---------------------------------------------------------------------------
// tag_fifo
// In-order FIFO of 1-bit owner tags for address-accepted, data-pending
// transactions.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write push_tag (ignored when full)
//   push_tag    : tag to store
//   pop         : drop the head entry (ignored when empty)
//   head        : tag at the read pointer
//   full/empty  : registered occupancy flags
//   count       : number of stored tags, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          tags [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = tags[rd_ptr];

    // Pointers and count; a simultaneous push and pop leaves the count alone
    // while both pointers step forward.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tags[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like memory port between the instruction-fetch (inst) and
// load/store (data) requesters. Data has priority, with a starvation guard
// that forces inst through after STARVE_MAX consecutive data grants while
// inst waits. A grant that is not accepted immediately is locked until its
// address handshake completes. Accepted transactions are tagged in order so
// each mem_data_ok is routed back to the requester that issued it.
//
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   inst_sram_* / data_sram_* : requester bundles (req, wr, size, wstrb,
//                            addr, wdata in; addr_ok, data_ok, rdata out)
//   mem_*                  : shared downstream port (req, wr, size, wstrb,
//                            addr, wdata out; addr_ok, data_ok, rdata in)
//   err_orphan             : sticky flag, a response arrived with nothing
//                            outstanding
// ---------------------------------------------------------------------------
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_orphan
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(OUTST_DEPTH) + 1;

    arb_state_e  state;
    logic [SW-1:0] starve_cnt;

    sram_req_t   inst_bundle;
    sram_req_t   data_bundle;
    sram_req_t   sel_bundle;

    owner_e      winner;
    owner_e      owner;
    logic        inst_forced;
    logic        any_req;
    logic        req_int;
    logic        handshake;
    logic        resp_valid;
    logic        orphan_evt;

    logic        fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        fifo_blocked;

    assign inst_bundle = '{wr: inst_sram_wr, size: inst_sram_size,
                           wstrb: inst_sram_wstrb, addr: inst_sram_addr,
                           wdata: inst_sram_wdata};
    assign data_bundle = '{wr: data_sram_wr, size: data_sram_size,
                           wstrb: data_sram_wstrb, addr: data_sram_addr,
                           wdata: data_sram_wdata};

    // Full is judged on the registered count only, so a response popping in
    // the same cycle does not open the door until the next one. This also
    // keeps mem_addr_ok/mem_data_ok out of the mem_req cone.
    assign fifo_blocked = (fifo_count == CW'(OUTST_DEPTH));

    // Free-running priority choice used only while no grant is locked:
    // data first, unless inst has waited through STARVE_MAX data grants.
    always_comb begin
        inst_forced = inst_sram_req && (starve_cnt == SW'(STARVE_MAX));
        any_req     = inst_sram_req | data_sram_req;
        if (inst_forced) begin
            winner = OWN_INST;
        end else if (data_sram_req) begin
            winner = OWN_DATA;
        end else begin
            winner = OWN_INST;
        end
    end

    // Current owner of the port and whether a request is presented. In HOLD
    // the requester is obliged to keep its request up, so req is forced on.
    always_comb begin
        owner   = winner;
        req_int = 1'b0;
        case (state)
            S_HOLD_I: begin
                owner   = OWN_INST;
                req_int = 1'b1;
            end
            S_HOLD_D: begin
                owner   = OWN_DATA;
                req_int = 1'b1;
            end
            default: begin
                owner   = winner;
                req_int = any_req & ~fifo_blocked;
            end
        endcase
    end

    assign sel_bundle = (owner == OWN_DATA) ? data_bundle : inst_bundle;
    assign handshake  = req_int & mem_addr_ok;
    assign resp_valid = mem_data_ok & ~fifo_empty;
    assign orphan_evt = mem_data_ok & fifo_empty;

    // Every output is held at zero while reset is asserted, even though the
    // forwarding paths are combinational from the requesters.
    assign mem_req = resetn & req_int;
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} =
        resetn ? sel_bundle : '0;

    assign inst_sram_addr_ok = resetn & handshake & (owner == OWN_INST);
    assign data_sram_addr_ok = resetn & handshake & (owner == OWN_DATA);

    assign inst_sram_data_ok = resetn & resp_valid & (fifo_head == OWN_INST);
    assign data_sram_data_ok = resetn & resp_valid & (fifo_head == OWN_DATA);

    assign inst_sram_rdata = resetn ? mem_rdata : '0;
    assign data_sram_rdata = resetn ? mem_rdata : '0;

    // Arbiter FSM: an unacknowledged request in IDLE locks the grant to the
    // winner until the address handshake completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_int && !mem_addr_ok) begin
                        state <= hold_state(winner);
                    end
                end
                S_HOLD_I, S_HOLD_D: begin
                    if (mem_addr_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counts data handshakes that happened while inst was waiting; saturates
    // so inst keeps its forced win until it actually gets through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!inst_sram_req) begin
            starve_cnt <= '0;
        end else if (handshake && owner == OWN_INST) begin
            starve_cnt <= '0;
        end else if (handshake && owner == OWN_DATA &&
                     starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Sticky: a response with nothing outstanding means the bridge and this
    // block disagree about what is in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_orphan <= 1'b0;
        end else if (orphan_evt) begin
            err_orphan <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (handshake),
        .push_tag (owner),
        .pop      (mem_data_ok),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // A HOLD is only entered with room in the FIFO, and the count can only
    // fall while holding, so a locked grant never sees a full FIFO.
    hold_never_full: assert property (
        @(posedge clk) disable iff (!resetn) (state != S_IDLE) |-> !fifo_full
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Drives both requesters and a simple memory slave, predicts the arbiter's
// behaviour with a queue-based reference model, and checks responses through
// a scoreboard popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;
    localparam logic [31:0] RKEY = 32'h5A5A_0000;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err_orphan;

    sram_req_arbiter #(
        .OUTST_DEPTH (DEPTH),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata),
        .err_orphan        (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          side;
        logic [31:0] rdata;
    } sb_t;

    int errors = 0;
    int checks = 0;

    // Requester state: a pending request and its 71-bit bundle
    // {wr, size, wstrb, addr, wdata}.
    bit          ireq_active, dreq_active;
    logic [70:0] ireq_b, dreq_b;

    // Reference model: locked owner, in-order outstanding owners, starvation
    // count, sticky orphan flag.
    bit          locked;
    bit          lock_own;
    bit          outst[$];
    int          starve;
    bit          m_orphan;

    sb_t         sb[$];
    logic [31:0] mem_q[$];

    bit          log_en;
    bit          hs_log[$];

    task automatic compareValue(input string name, input logic [70:0] act,
                                input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [70:0] newBundle(input logic [3:0] tag);
        logic [70:0] b;
        b = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom),
             tag, 28'($urandom), 32'($urandom)};
        return b;
    endfunction

    task automatic driveInputs();
        inst_sram_req = ireq_active;
        {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = ireq_b;
        data_sram_req = dreq_active;
        {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = dreq_b;
    endtask

    task automatic applyStimulus(input bit s_i, input bit s_d, input bit aok,
                                 input bit dok, input bit force_orphan);
        if (!ireq_active && s_i) begin
            ireq_active = 1'b1;
            ireq_b = newBundle(4'h1);
        end
        if (!dreq_active && s_d) begin
            dreq_active = 1'b1;
            dreq_b = newBundle(4'h8);
        end
        driveInputs();
        mem_addr_ok = aok;
        mem_data_ok = dok && (mem_q.size() > 0 || force_orphan);
        mem_rdata   = (mem_data_ok && mem_q.size() > 0) ? mem_q[0] : 32'($urandom);
    endtask

    task automatic checkOutput();
        bit exp_req, own, hs, pop, head, empty_before;
        logic [70:0] exp_b;
        exp_req = 1'b0;
        own     = 1'b0;
        if (locked) begin
            exp_req = 1'b1;
            own     = lock_own;
        end else if (outst.size() >= DEPTH) begin
            exp_req = 1'b0;
        end else if (inst_sram_req && starve == SMAX) begin
            exp_req = 1'b1;
            own     = 1'b0;
        end else if (data_sram_req) begin
            exp_req = 1'b1;
            own     = 1'b1;
        end else if (inst_sram_req) begin
            exp_req = 1'b1;
            own     = 1'b0;
        end
        hs           = exp_req && mem_addr_ok;
        empty_before = (outst.size() == 0);
        pop          = mem_data_ok && !empty_before;
        head         = pop ? outst[0] : 1'b0;
        exp_b        = own ? dreq_b : ireq_b;

        compareValue("mem_req", 71'(mem_req), 71'(exp_req));
        if (exp_req)
            compareValue("mem_bundle", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_b);
        compareValue("inst_addr_ok", 71'(inst_sram_addr_ok), 71'(hs && !own));
        compareValue("data_addr_ok", 71'(data_sram_addr_ok), 71'(hs && own));
        compareValue("inst_data_ok", 71'(inst_sram_data_ok), 71'(pop && !head));
        compareValue("data_data_ok", 71'(data_sram_data_ok), 71'(pop && head));
        compareValue("err_orphan", 71'(err_orphan), 71'(m_orphan));
        compareValue("rdata_bcast", 71'(inst_sram_rdata), 71'(mem_rdata));

        if (log_en && inst_sram_addr_ok) hs_log.push_back(1'b0);
        if (log_en && data_sram_addr_ok) hs_log.push_back(1'b1);

        // Memory slave: responds in order with data derived from the address
        // it actually saw on the port.
        if (mem_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
        if (mem_req && mem_addr_ok) mem_q.push_back(mem_addr ^ RKEY);

        if (mem_data_ok && empty_before) m_orphan = 1'b1;
        if (pop) void'(outst.pop_front());
        if (hs) begin
            outst.push_back(own);
            sb.push_back('{side: own, rdata: exp_b[63:32] ^ RKEY});
            locked = 1'b0;
            if (own) dreq_active = 1'b0;
            else     ireq_active = 1'b0;
        end else if (exp_req) begin
            locked   = 1'b1;
            lock_own = own;
        end
        if (!inst_sram_req)          starve = 0;
        else if (hs && !own)         starve = 0;
        else if (hs && starve < SMAX) starve++;
    endtask

    task automatic cycle(input bit s_i, input bit s_d, input bit aok,
                         input bit dok, input bit force_orphan);
        @(posedge clk);
        #1;
        applyStimulus(s_i, s_d, aok, dok, force_orphan);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        compareValue({tag, "_mem_req"}, 71'(mem_req), 71'(0));
        compareValue({tag, "_mem_bundle"}, {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, 71'(0));
        compareValue({tag, "_addr_ok"}, 71'({inst_sram_addr_ok, data_sram_addr_ok}), 71'(0));
        compareValue({tag, "_data_ok"}, 71'({inst_sram_data_ok, data_sram_data_ok}), 71'(0));
        compareValue({tag, "_rdata"}, 71'({inst_sram_rdata, data_sram_rdata}), 71'(0));
        compareValue({tag, "_err_orphan"}, 71'(err_orphan), 71'(0));
    endtask

    // Response monitor: whenever the DUT flags a response, it must match the
    // oldest transaction the model accepted.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (resetn && (inst_sram_data_ok || data_sram_data_ok)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL resp_unexpected: got data_ok %b%b expected none",
                         inst_sram_data_ok, data_sram_data_ok);
            end else begin
                e = sb.pop_front();
                compareValue("resp_both", 71'(inst_sram_data_ok && data_sram_data_ok), 71'(0));
                compareValue("resp_side", 71'(data_sram_data_ok), 71'(e.side));
                compareValue("resp_rdata", 71'(e.side ? data_sram_rdata : inst_sram_rdata), 71'(e.rdata));
            end
        end
    end

    initial begin
        logic [7:0] pat;
        resetn = 1'b0;
        ireq_active = 1'b0; dreq_active = 1'b0;
        ireq_b = '0; dreq_b = '0;
        locked = 1'b0; lock_own = 1'b0; starve = 0; m_orphan = 1'b0;
        log_en = 1'b0;
        driveInputs();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hCAFE_F00D;
        #3;
        checkAllZero("reset");
        #9 resetn = 1'b1;

        // Data priority: both request together, data goes first.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Grant lock: inst held for 3 cycles while data arrives.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // Full: four handshakes, fifth blocked until one response returns.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // Starvation: continuous requests from both sides.
        log_en = 1'b1;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        log_en = 1'b0;
        pat = 8'b1110_1110;
        if (hs_log.size() < 8) begin
            checks++;
            errors++;
            $display("[TB] FAIL starve_count: got %0d handshakes expected at least 8", hs_log.size());
        end else begin
            for (int i = 0; i < 8; i++)
                compareValue($sformatf("starve_seq%0d", i), 71'(hs_log[i]), 71'(pat[7-i]));
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'b0);
        drain();

        // Orphan response with nothing outstanding.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a HOLD with two transactions outstanding.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        #1 resetn = 1'b0;
        #1;
        checkAllZero("midreset");
        ireq_active = 1'b0;
        dreq_active = 1'b0;
        driveInputs();
        mem_data_ok = 1'b0;
        locked = 1'b0; starve = 0; m_orphan = 1'b0;
        outst.delete();
        sb.delete();
        @(negedge clk);
        #2 resetn = 1'b1;

        // Responses still in flight from before reset are now orphans.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        compareValue("sb_drained", 71'(sb.size()), 71'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
